rpn_ctrl: RTL and testbench

RPN_CTRL -- requirements
Module: rpn_ctrl

---
 rtl/rpn_ctrl_if.sv | 28 ++
 rtl/rpn_ctrl.sv | 149 ++++++++++++++
 tb/tb_rpn_ctrl.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rpn_ctrl_if.sv
// rpn_ctrl_if: token handshake, downstream stack request bus and result/status
// signals of the RPN controller, bundled for port connection.
// slave  = the controller's view, master = the environment (token source + stack).
interface rpn_ctrl_if #(
    parameter int WORD_BITS = 4
);
    logic                 tok_valid;
    logic                 tok_ready;
    logic                 tok_is_op;
    logic [WORD_BITS-1:0] tok_data;
    logic                 stk_push;
    logic                 stk_pop;
    logic [WORD_BITS-1:0] stk_push_data;
    logic [WORD_BITS-1:0] stk_pop_data;
    logic [WORD_BITS-1:0] result;
    logic                 result_valid;
    logic                 err;

    modport master (
        output tok_valid, tok_is_op, tok_data, stk_pop_data,
        input  tok_ready, stk_push, stk_pop, stk_push_data, result, result_valid, err
    );

    modport slave (
        input  tok_valid, tok_is_op, tok_data, stk_pop_data,
        output tok_ready, stk_push, stk_pop, stk_push_data, result, result_valid, err
    );
endinterface

// File: rtl/rpn_ctrl.sv
// rpn_ctrl: RPN evaluation controller driving an external stack.
// Operands are pushed; operators pop b then a, push (a op b) and publish the result.
// Occupancy is tracked only by an internal depth counter; underflow/overflow
// parks the FSM in a sticky ERR state until reset.
// Optional feature: define RPN_SAT_EN to saturate ADD/SUB instead of wrapping.
module rpn_ctrl #(
    parameter int ADDRESS_BITS = 2,
    parameter int WORD_BITS    = 4
) (
    input  logic       clk,
    input  logic       rst,
    rpn_ctrl_if.slave  bus
);
    localparam int DW = ADDRESS_BITS + 1;
    localparam logic [DW-1:0] DEPTH_MAX = DW'(2 ** ADDRESS_BITS);
    localparam logic [DW-1:0] DEPTH_TWO = DW'(2);

    typedef enum logic [2:0] {
        IDLE, PUSH, POP_B, POP_A, WAIT_A, EXEC, ERR
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [DW-1:0]        r_depth;
    logic [WORD_BITS-1:0] r_operand;
    logic [1:0]           r_op;
    logic [WORD_BITS-1:0] r_a;
    logic [WORD_BITS-1:0] r_b;
    logic [WORD_BITS-1:0] r_result;
    logic                 r_result_valid;

    logic                 w_accept;
    logic                 w_tok_ready;
    logic                 w_stk_push;
    logic                 w_stk_pop;
    logic [WORD_BITS-1:0] w_stk_push_data;
    logic [WORD_BITS-1:0] w_add;
    logic [WORD_BITS-1:0] w_sub;
    logic [WORD_BITS-1:0] w_alu;

    assign w_accept = bus.tok_valid & w_tok_ready;

`ifdef RPN_SAT_EN
    logic [WORD_BITS:0] w_sum;
    logic [WORD_BITS:0] w_diff;
    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff = {1'b0, r_a} - {1'b0, r_b};
    // carry-out clamps to all ones, borrow clamps to zero
    assign w_add  = w_sum[WORD_BITS]  ? '1 : w_sum[WORD_BITS-1:0];
    assign w_sub  = w_diff[WORD_BITS] ? '0 : w_diff[WORD_BITS-1:0];
`else
    assign w_add  = r_a + r_b;
    assign w_sub  = r_a - r_b;
`endif

    // operator result; a is the deeper entry, so SUB is a - b
    always_comb begin
        w_alu = w_add;
        case (r_op)
            2'd0:    w_alu = w_add;
            2'd1:    w_alu = w_sub;
            2'd2:    w_alu = r_a & r_b;
            default: w_alu = r_a | r_b;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // next-state decode and state-driven stack requests
    always_comb begin
        w_state_next    = r_state;
        w_tok_ready     = 1'b0;
        w_stk_push      = 1'b0;
        w_stk_pop       = 1'b0;
        w_stk_push_data = '0;
        case (r_state)
            IDLE: begin
                w_tok_ready = 1'b1;
                if (bus.tok_valid) begin
                    if (bus.tok_is_op)
                        w_state_next = (r_depth < DEPTH_TWO) ? ERR : POP_B;
                    else
                        w_state_next = (r_depth == DEPTH_MAX) ? ERR : PUSH;
                end
            end
            PUSH: begin
                w_stk_push      = 1'b1;
                w_stk_push_data = r_operand;
                w_state_next    = IDLE;
            end
            POP_B: begin
                w_stk_pop    = 1'b1;
                w_state_next = POP_A;
            end
            POP_A: begin
                w_stk_pop    = 1'b1;
                w_state_next = WAIT_A;
            end
            WAIT_A: w_state_next = EXEC;
            EXEC: begin
                w_stk_push      = 1'b1;
                w_stk_push_data = w_alu;
                w_state_next    = IDLE;
            end
            ERR:     w_state_next = ERR;
            default: w_state_next = IDLE;
        endcase
    end

    // token latch, operand capture from the stack, depth and result bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_depth        <= '0;
            r_operand      <= '0;
            r_op           <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_result       <= '0;
            r_result_valid <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            if (w_accept) begin
                r_operand <= bus.tok_data;
                r_op      <= bus.tok_data[1:0];
            end
            // popped data shows up one cycle after each pop request
            if (r_state == POP_A)  r_b <= bus.stk_pop_data;
            if (r_state == WAIT_A) r_a <= bus.stk_pop_data;
            if (r_state == PUSH)   r_depth <= r_depth + DW'(1);
            if (r_state == EXEC) begin
                r_depth        <= r_depth - DW'(1);
                r_result       <= w_alu;
                r_result_valid <= 1'b1;
            end
        end
    end

    assign bus.tok_ready     = w_tok_ready;
    assign bus.stk_push      = w_stk_push;
    assign bus.stk_pop       = w_stk_pop;
    assign bus.stk_push_data = w_stk_push_data;
    assign bus.result        = r_result;
    assign bus.result_valid  = r_result_valid;
    assign bus.err           = (r_state == ERR);
endmodule

// File: tb/tb_rpn_ctrl.sv
// tb_rpn_ctrl: scoreboard bench for rpn_ctrl with a behavioural downstream stack.
// A reference RPN model predicts each stack push and operator result when the
// token is driven; the monitor pops and compares when the DUT produces them.
module tb_rpn_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rpn_ctrl_if #(.WORD_BITS(4)) bus();

    rpn_ctrl #(.ADDRESS_BITS(2), .WORD_BITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // behavioural stack: pop data valid the cycle after stk_pop
    logic [3:0] stk_mem [0:7];
    int         sp = 0;
    logic [3:0] pop_q = 4'h0;
    always @(posedge clk) begin
        if (rst) begin
            sp    <= 0;
            pop_q <= 4'h0;
        end else if (bus.stk_push) begin
            if (sp < 8) stk_mem[sp] <= bus.stk_push_data;
            sp <= sp + 1;
        end else if (bus.stk_pop) begin
            pop_q <= (sp > 0) ? stk_mem[sp-1] : 4'h0;
            sp    <= (sp > 0) ? sp - 1 : 0;
        end
    end
    assign bus.stk_pop_data = pop_q;

    // scoreboard state
    int exp_push[$];
    int exp_res[$];
    int mstk[$];
    bit exp_err = 1'b0;

    int cyc           = 0;
    int push_count    = 0;
    int pop_count     = 0;
    int last_push_cyc = -1;
    int last_res_cyc  = -1;
    int last_acc      = -1;
    bit prev_rv       = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: sampled mid-cycle, compares DUT output against the scoreboard
    always @(negedge clk) begin
        int e;
        check_eq("push_pop_excl", int'(bus.stk_push & bus.stk_pop), 0);
        if (!rst) begin
            if (bus.stk_push) begin
                push_count++;
                last_push_cyc = cyc;
                if (exp_push.size() > 0) e = exp_push.pop_front();
                else                     e = -1;
                check_eq("push_data", int'(bus.stk_push_data), e);
            end
            if (bus.stk_pop) pop_count++;
            if (bus.result_valid) begin
                last_res_cyc = cyc;
                if (exp_res.size() > 0) e = exp_res.pop_front();
                else                    e = -1;
                check_eq("result", int'(bus.result), e);
                check_eq("rv_one_cycle", int'(prev_rv), 0);
            end
        end
        prev_rv = bus.result_valid;
    end

    function automatic int calc(input int op, input int a, input int b);
        int r;
        case (op)
            0: begin
                r = a + b;
`ifdef RPN_SAT_EN
                if (r > 15) r = 15;
`else
                r = r % 16;
`endif
            end
            1: begin
`ifdef RPN_SAT_EN
                r = (a < b) ? 0 : a - b;
`else
                r = (a < b) ? a - b + 16 : a - b;
`endif
            end
            2: r = a & b;
            default: r = a | b;
        endcase
        return r;
    endfunction

    // update the reference model, then offer the token until accepted
    task automatic send(input bit is_op, input int data);
        int a, b, r, n;
        if (!exp_err) begin
            if (is_op) begin
                if (mstk.size() < 2) exp_err = 1'b1;
                else begin
                    b = mstk.pop_back();
                    a = mstk.pop_back();
                    r = calc(data % 4, a, b);
                    mstk.push_back(r);
                    exp_push.push_back(r);
                    exp_res.push_back(r);
                end
            end else begin
                if (mstk.size() == 4) exp_err = 1'b1;
                else begin
                    mstk.push_back(data);
                    exp_push.push_back(data);
                end
            end
        end
        bus.tok_valid = 1'b1;
        bus.tok_is_op = is_op;
        bus.tok_data  = data[3:0];
        n = 0;
        while (!bus.tok_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.tok_ready) begin
            check_eq("tok_ready_timeout", int'(bus.tok_ready), 1);
            last_acc = -1;
        end else begin
            last_acc = cyc;
            @(negedge clk);
        end
        bus.tok_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.tok_valid = 1'b0;
        exp_push.delete();
        exp_res.delete();
        mstk.delete();
        exp_err = 1'b0;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic settle(input string tag);
        check_eq({tag, "_push_q_left"}, exp_push.size(), 0);
        check_eq({tag, "_res_q_left"}, exp_res.size(), 0);
        check_eq({tag, "_depth"}, sp, mstk.size());
        check_eq({tag, "_err"}, int'(bus.err), int'(exp_err));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, ao, pc, qc;
        bus.tok_valid = 1'b0;
        bus.tok_is_op = 1'b0;
        bus.tok_data  = 4'h0;

        // reset values
        do_reset();
        check_eq("rst_tok_ready", int'(bus.tok_ready), 1);
        check_eq("rst_err", int'(bus.err), 0);
        check_eq("rst_result", int'(bus.result), 0);
        check_eq("rst_result_valid", int'(bus.result_valid), 0);
        check_eq("rst_stk_push", int'(bus.stk_push), 0);
        check_eq("rst_stk_pop", int'(bus.stk_pop), 0);
        check_eq("rst_push_data", int'(bus.stk_push_data), 0);

        // 3 5 ADD with latency checks
        send(0, 3); a1 = last_acc;
        send(0, 5); a2 = last_acc;
        idle(2);
        check_eq("b2b_accept_gap", a2 - a1, 2);
        check_eq("operand_push_lat", last_push_cyc, a2 + 1);
        pc = pop_count;
        send(1, 0); ao = last_acc;
        idle(7);
        check_eq("op_push_lat", last_push_cyc, ao + 4);
        check_eq("result_lat", last_res_cyc, ao + 5);
        check_eq("op_pop_count", pop_count - pc, 2);
        check_eq("result_hold", int'(bus.result), 8);
        settle("add");

        // 2 7 SUB
        do_reset();
        send(0, 2); send(0, 7); send(1, 1);
        idle(7);
        settle("sub");

        // 9 9 ADD
        do_reset();
        send(0, 9); send(0, 9); send(1, 0);
        idle(7);
        settle("add_ovf");

        // 12 10 AND, 5 OR chained
        do_reset();
        send(0, 12); send(0, 10); send(1, 2);
        send(0, 5); send(1, 3);
        idle(7);
        check_eq("or_result", int'(bus.result), 13);
        settle("and_or");

        // underflow: one operand then AND
        do_reset();
        send(0, 6);
        idle(3);
        pc = pop_count;
        qc = push_count;
        send(1, 2);
        idle(2);
        for (int i = 0; i < 5; i++) begin
            check_eq("uf_err", int'(bus.err), 1);
            check_eq("uf_tok_ready", int'(bus.tok_ready), 0);
            idle(1);
        end
        check_eq("uf_no_pop", pop_count - pc, 0);
        check_eq("uf_no_push", push_count - qc, 0);
        settle("uf");

        // overflow: 1 2 3 4 then 5
        do_reset();
        qc = push_count;
        for (int i = 1; i <= 5; i++) send(0, i);
        idle(4);
        check_eq("of_push_count", push_count - qc, 4);
        check_eq("of_tok_ready", int'(bus.tok_ready), 0);
        settle("of");

        // reset while in WAIT_A aborts the operator
        do_reset();
        send(0, 3); send(0, 4);
        idle(2);
        qc = push_count;
        send(1, 0);
        idle(2);
        check_eq("wa_no_push_before_rst", int'(bus.stk_push), 0);
        rst = 1'b1;
        exp_push.delete();
        exp_res.delete();
        mstk.delete();
        exp_err = 1'b0;
        idle(1);
        rst = 1'b0;
        check_eq("wa_tok_ready", int'(bus.tok_ready), 1);
        check_eq("wa_err", int'(bus.err), 0);
        check_eq("wa_stk_push", int'(bus.stk_push), 0);
        idle(5);
        check_eq("wa_no_exec_push", push_count - qc, 0);
        pc = pop_count;
        send(1, 0);
        idle(3);
        check_eq("wa_depth0_err", int'(bus.err), 1);
        check_eq("wa_depth0_no_pop", pop_count - pc, 0);
        settle("wa");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
